// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the program counter, drives the instruction-memory address, and
// captures the fetched word plus its PC for the decode stage.
//
// Ports:
//   clk            in   core clock, rising-edge
//   reset          in   synchronous active-high reset
//   stall          in   hazard stall; holds PC and IF/ID
//   branch_taken   in   redirect from EX; flushes IF/ID
//   branch_target  in   redirect address (PC_WIDTH)
//   imem_addr      out  instruction-memory address (= PC)
//   imem_rdata     in   instruction word for imem_addr, same cycle
//   if_id_pc       out  PC of the instruction in IF/ID
//   if_id_instruc  out  instruction in IF/ID
//   if_id_valid    out  1 = real instruction, 0 = bubble
//   misalign_err   out  pulse: previous redirect target had low bits set
//   fetch_count    out  instructions loaded into IF/ID since reset
module if_stage_fetch #(
  parameter int unsigned           PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instruc,
  output logic                if_id_valid,
  output logic                misalign_err,
  output logic [31:0]         fetch_count
);

  localparam int unsigned INSTR_BYTES = 4;

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_if_id_pc;
  logic [31:0]         r_if_id_instruc;
  logic                r_if_id_valid;
  logic                r_misalign_err;
  logic [31:0]         r_fetch_count;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_target_aligned;
  logic                w_target_misaligned;

  // Sequential PC, word-aligned redirect target and its misalignment flag.
  assign w_pc_inc            = r_pc + PC_WIDTH'(INSTR_BYTES);
  assign w_target_aligned    = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign w_target_misaligned = (branch_target[1:0] != 2'b00);

  // PC and IF/ID update; priority is reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_if_id_pc      <= '0;
      r_if_id_instruc <= NOP_INSTR;
      r_if_id_valid   <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_fetch_count   <= '0;
    end else if (branch_taken) begin
      // Redirect overrides stall and inserts a bubble; count is untouched.
      r_pc            <= w_target_aligned;
      r_if_id_pc      <= '0;
      r_if_id_instruc <= NOP_INSTR;
      r_if_id_valid   <= 1'b0;
      r_misalign_err  <= w_target_misaligned;
    end else begin
      r_misalign_err <= 1'b0;
      if (!stall) begin
        r_pc            <= w_pc_inc;
        r_if_id_pc      <= r_pc;
        r_if_id_instruc <= imem_rdata;
        r_if_id_valid   <= 1'b1;
        r_fetch_count   <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign if_id_pc      = r_if_id_pc;
  assign if_id_instruc = r_if_id_instruc;
  assign if_id_valid   = r_if_id_valid;
  assign misalign_err  = r_misalign_err;
  assign fetch_count   = r_fetch_count;

endmodule
